// File: rtl/alsu_pkg.sv
// Shared types and helpers for the pipelined ALSU: opcode encoding, operand-priority
// selectors and the invalid-operation predicate used by the evaluator.
package alsu_pkg;

    typedef enum logic [2:0] {
        OP_OR     = 3'd0,
        OP_XOR    = 3'd1,
        OP_ADD    = 3'd2,
        OP_MULT   = 3'd3,
        OP_SHIFT  = 3'd4,
        OP_ROTATE = 3'd5,
        OP_INV6   = 3'd6,
        OP_INV7   = 3'd7
    } opcode_e;

    localparam bit PRIO_A = 1'b0;
    localparam bit PRIO_B = 1'b1;

    // Reductions are only meaningful for the logic ops; anywhere else they mark the request bad.
    function automatic logic is_invalid(opcode_e op, logic red_a, logic red_b);
        return (op == OP_INV6) || (op == OP_INV7) ||
               ((red_a || red_b) && !(op == OP_OR || op == OP_XOR));
    endfunction

endpackage

// File: rtl/alsu_core.sv
// Combinational ALSU evaluator: maps the staged request plus the current result register
// to the next result and an invalid-operation indication.
module alsu_core
    import alsu_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int OUT_W   = 2 * WIDTH,
    parameter bit PRIO    = PRIO_A,
    parameter bit USE_CIN = 1'b1
) (
    input  opcode_e                  op,
    input  logic signed [WIDTH-1:0]  a,
    input  logic signed [WIDTH-1:0]  b,
    input  logic                     cin,
    input  logic                     serial_in,
    input  logic                     direction,
    input  logic                     red_op_a,
    input  logic                     red_op_b,
    input  logic                     bypass_a,
    input  logic                     bypass_b,
    input  logic [OUT_W-1:0]         cur_out,
    output logic [OUT_W-1:0]         nxt_out,
    output logic                     invalid
);

    logic signed [OUT_W-1:0] a_ext;
    logic signed [OUT_W-1:0] b_ext;
    logic [OUT_W-1:0]        cin_ext;
    logic                    use_a_red;
    logic                    use_a_byp;
    logic [WIDTH-1:0]        red_opnd;

    always_comb begin
        invalid   = is_invalid(op, red_op_a, red_op_b);
        a_ext     = {{(OUT_W-WIDTH){a[WIDTH-1]}}, a};
        b_ext     = {{(OUT_W-WIDTH){b[WIDTH-1]}}, b};
        cin_ext   = USE_CIN ? {{(OUT_W-1){1'b0}}, cin} : '0;
        use_a_red = red_op_a && (!red_op_b || PRIO == PRIO_A);
        use_a_byp = bypass_a && (!bypass_b || PRIO == PRIO_A);
        red_opnd  = use_a_red ? a : b;
        nxt_out   = '0;

        if (invalid) begin
            nxt_out = '0;
        end else if (bypass_a || bypass_b) begin
            nxt_out = use_a_byp ? a_ext : b_ext;
        end else begin
            case (op)
                OP_OR:     nxt_out = (red_op_a || red_op_b) ? {{(OUT_W-1){1'b0}}, |red_opnd}
                                                            : (a_ext | b_ext);
                OP_XOR:    nxt_out = (red_op_a || red_op_b) ? {{(OUT_W-1){1'b0}}, ^red_opnd}
                                                            : (a_ext ^ b_ext);
                OP_ADD:    nxt_out = a_ext + b_ext + cin_ext;
                // OUT_W = 2*WIDTH, so the signed product never truncates.
                OP_MULT:   nxt_out = a_ext * b_ext;
                OP_SHIFT:  nxt_out = direction ? {cur_out[OUT_W-2:0], serial_in}
                                               : {serial_in, cur_out[OUT_W-1:1]};
                OP_ROTATE: nxt_out = direction ? {cur_out[OUT_W-2:0], cur_out[OUT_W-1]}
                                               : {cur_out[0], cur_out[OUT_W-1:1]};
                default:   nxt_out = '0;
            endcase
        end
    end

endmodule

// File: rtl/alsu_pipe.sv
// Two-stage valid/ready ALSU pipeline with error-blink LEDs.
// Define ALSU_ERR_CNT_EN to add the saturating err_cnt output counting retired invalid ops.
module alsu_pipe
    import alsu_pkg::*;
#(
    parameter int    WIDTH          = 3,
    parameter int    OUT_W          = 2 * WIDTH,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    LED_W          = 16,
    parameter int    BLINK_DIV      = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              opcode,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    input  logic                    cin,
    input  logic                    serial_in,
    input  logic                    direction,
    input  logic                    red_op_A,
    input  logic                    red_op_B,
    input  logic                    bypass_A,
    input  logic                    bypass_B,
    output logic signed [OUT_W-1:0] out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LED_W-1:0]        leds
`ifdef ALSU_ERR_CNT_EN
    ,
    output logic [7:0]              err_cnt
`endif
);

    localparam bit PRIO    = (INPUT_PRIORITY == "B") ? PRIO_B : PRIO_A;
    localparam bit USE_CIN = (FULL_ADDER == "ON");
    localparam int CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    logic                    s1_valid;
    opcode_e                 s1_op;
    logic signed [WIDTH-1:0] s1_a;
    logic signed [WIDTH-1:0] s1_b;
    logic                    s1_cin;
    logic                    s1_serial_in;
    logic                    s1_direction;
    logic                    s1_red_a;
    logic                    s1_red_b;
    logic                    s1_byp_a;
    logic                    s1_byp_b;

    logic                    advance;
    logic [OUT_W-1:0]        core_out;
    logic                    core_invalid;
    logic                    err_flag;
    logic [CNT_W-1:0]        blink_cnt;

    always_comb begin
        advance  = s1_valid && (!out_valid || out_ready);
        in_ready = !s1_valid || advance;
    end

    alsu_core #(
        .WIDTH   (WIDTH),
        .OUT_W   (OUT_W),
        .PRIO    (PRIO),
        .USE_CIN (USE_CIN)
    ) u_core (
        .op        (s1_op),
        .a         (s1_a),
        .b         (s1_b),
        .cin       (s1_cin),
        .serial_in (s1_serial_in),
        .direction (s1_direction),
        .red_op_a  (s1_red_a),
        .red_op_b  (s1_red_b),
        .bypass_a  (s1_byp_a),
        .bypass_b  (s1_byp_b),
        .cur_out   (out),
        .nxt_out   (core_out),
        .invalid   (core_invalid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_op        <= OP_OR;
            s1_a         <= '0;
            s1_b         <= '0;
            s1_cin       <= 1'b0;
            s1_serial_in <= 1'b0;
            s1_direction <= 1'b0;
            s1_red_a     <= 1'b0;
            s1_red_b     <= 1'b0;
            s1_byp_a     <= 1'b0;
            s1_byp_b     <= 1'b0;
            out          <= '0;
            out_valid    <= 1'b0;
            err_flag     <= 1'b0;
            blink_cnt    <= '0;
            leds         <= '0;
        end else begin
            if (in_valid && in_ready) begin
                s1_valid     <= 1'b1;
                s1_op        <= opcode_e'(opcode);
                s1_a         <= A;
                s1_b         <= B;
                s1_cin       <= cin;
                s1_serial_in <= serial_in;
                s1_direction <= direction;
                s1_red_a     <= red_op_A;
                s1_red_b     <= red_op_B;
                s1_byp_a     <= bypass_A;
                s1_byp_b     <= bypass_B;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end

            if (advance) begin
                out       <= core_out;
                out_valid <= 1'b1;
                err_flag  <= core_invalid;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (err_flag) begin
                if (blink_cnt == CNT_MAX) begin
                    blink_cnt <= '0;
                    leds      <= ~leds;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else begin
                blink_cnt <= '0;
                leds      <= '0;
            end
        end
    end

`ifdef ALSU_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (advance && core_invalid && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
